vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have port: clock  in  1  system clock; all state changes on posedge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: ce  in  1  slot enable; one memory slot per clock with ce=1.
REQ-004 SHALL have ports: vid_req in 1 video fetch request, sampled per slot, no hold; vid_a in 14 video address.
REQ-005 SHALL have ports: vid_q out 8 fetched byte; vid_valid out 1 one-clock data strobe; vid_miss out 1 one-clock dropped-request strobe.
REQ-006 SHALL have ports: cpu_req in 1 level request, held until ack; cpu_we in 1 write=1; cpu_a in 14; cpu_d in 8.
REQ-007 SHALL have ports: cpu_q out 8 read byte; cpu_ack out 1 one-clock completion strobe; cpu_wait out 1 Z80 wait, = cpu_req & ~cpu_ack (combinational).
REQ-008 SHALL have ports: mem_a out 14; mem_we out 1; mem_d out 8; mem_q in 8 single-port VRAM bank port.

Function
REQ-009 Slot k SHALL start at ce edge E_k; mem_a/mem_we/mem_d registered at E_k, held for the whole slot.
REQ-010 Memory SHALL perform the access at E_{k+1}; arbiter SHALL capture mem_q at E_{k+2} into vid_q or cpu_q and strobe vid_valid or cpu_ack for exactly one clock.
REQ-011 Owner register SHALL take states IDLE, VID, CPU; a second register SHALL hold previous-slot owner for the capture stage.
REQ-012 Per ce edge, owner: VID if vid_req and not forced-CPU; else CPU if CPU eligible; else IDLE.
REQ-013 CPU SHALL be eligible only when cpu_req=1 and neither current nor previous slot owner is CPU (at most one CPU grant per three slots, no double-grant).
REQ-014 IDLE slot: mem_we=0, mem_a/mem_d hold last values, no strobe at capture.
REQ-015 VID slot: mem_a=vid_a, mem_we=0.
REQ-016 CPU slot: mem_a=cpu_a, mem_d=cpu_d, mem_we=cpu_we; on write cpu_ack still strobes at E_{k+2}, cpu_q unchanged.
REQ-017 Clocks with ce=0 SHALL change no state and raise no strobe; strobes SHALL drop on next clock regardless of ce.
REQ-018 Simultaneous vid_req and eligible cpu_req SHALL grant video (subject to REQ-025).
REQ-019 cpu_req dropped before ack SHALL abandon nothing already issued; ack still strobes, later requests unaffected.

Reset
REQ-020 reset=1 at a clock edge SHALL set owner and previous owner to IDLE and clear starve counter.
REQ-021 Reset values: vid_q=0, cpu_q=0, vid_valid=0, vid_miss=0, cpu_ack=0, mem_a=0, mem_we=0, mem_d=0.
REQ-022 Reset mid-operation SHALL abandon in-flight slots: no vid_valid or cpu_ack for them; mem_we=0 from that edge.
REQ-023 reset SHALL take priority over ce.

Configuration
REQ-024 Macro VRAM_ARBITER_STARVE_GUARD_EN SHALL select starvation guard.
REQ-025 Defined: 3-bit counter counts consecutive VID slots while CPU eligible; at 4, next slot forced CPU, vid_miss strobes one clock at that ce edge, counter clears; counter clears on any non-VID slot or CPU ineligible.
REQ-026 Undefined: strict video priority, counter absent, vid_miss tied 0.

Verification
REQ-027 ce every clock, vid_req=1 one slot, vid_a=0x0123, mem_q=0x5A -> mem_a=0x0123 next slot, vid_valid one clock two edges later, vid_q=0x5A.
REQ-028 cpu_req=1 cpu_we=1 cpu_a=0x2000 cpu_d=0xC3, no vid_req -> one slot mem_we=1 mem_d=0xC3, cpu_ack one clock, cpu_wait low only that clock, no second grant.
REQ-029 vid_req and cpu read both set on same edge -> VID first, CPU next slot; vid_valid one clock before cpu_ack.
REQ-030 With guard: vid_req held 1, cpu_req held 1 -> 4 VID slots, 5th CPU, vid_miss strobes once; without guard: CPU never granted, cpu_wait stays 1.
REQ-031 ce every 4th clock, cpu read in flight, reset pulsed before capture -> no cpu_ack, all outputs at reset values, next request served normally.

Source files
------------

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_arbiter
//  Description : Slot-based arbiter sharing one single-port VRAM bank between
//                a video fetcher (priority, no hold) and a Z80 CPU port
//                (level request with wait). One memory slot per ce clock:
//                address phase at E_k, memory access at E_{k+1}, data
//                capture and strobe at E_{k+2}.
//  Options     : VRAM_ARBITER_STARVE_GUARD_EN -- when defined, forces a CPU
//                slot after four consecutive video slots that kept an
//                eligible CPU waiting; the dropped video fetch is flagged
//                on vid_miss.
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        vid_req,
    input  logic [13:0] vid_a,
    output logic [7:0]  vid_q,
    output logic        vid_valid,
    output logic        vid_miss,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_a,
    input  logic [7:0]  cpu_d,
    output logic [7:0]  cpu_q,
    output logic        cpu_ack,
    output logic        cpu_wait,
    output logic [13:0] mem_a,
    output logic        mem_we,
    output logic [7:0]  mem_d,
    input  logic [7:0]  mem_q
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

`ifdef VRAM_ARBITER_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_LIMIT = 3'd4;
`endif

    owner_t      owner_q, owner_d;
    owner_t      prev_q, prev_d;
    logic        prev_we_q, prev_we_d;
    logic [13:0] mem_a_q, mem_a_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_d_q, mem_d_d;
    logic [7:0]  vid_q_q, vid_q_d;
    logic        vid_valid_q, vid_valid_d;
    logic [7:0]  cpu_q_q, cpu_q_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        cpu_elig;
    logic        force_cpu;

`ifdef VRAM_ARBITER_STARVE_GUARD_EN
    logic [2:0]  starve_q, starve_d;
    logic        vid_miss_q, vid_miss_d;
`endif

    // Slot arbitration, address-phase registers and capture stage.
    always_comb begin
        owner_d     = owner_q;
        prev_d      = prev_q;
        prev_we_d   = prev_we_q;
        mem_a_d     = mem_a_q;
        mem_we_d    = mem_we_q;
        mem_d_d     = mem_d_q;
        vid_q_d     = vid_q_q;
        cpu_q_d     = cpu_q_q;
        // Strobes live for exactly one clock, whether or not ce is high.
        vid_valid_d = 1'b0;
        cpu_ack_d   = 1'b0;
        // A CPU grant blocks the next two slots so one request never
        // gets served twice while its ack is still in the pipe.
        cpu_elig    = cpu_req && (owner_q != OWN_CPU) && (prev_q != OWN_CPU);
        force_cpu   = 1'b0;
`ifdef VRAM_ARBITER_STARVE_GUARD_EN
        starve_d    = starve_q;
        vid_miss_d  = 1'b0;
        force_cpu   = (starve_q == STARVE_LIMIT) && cpu_elig && vid_req;
`endif

        if (ce) begin
            if (vid_req && !force_cpu) begin
                owner_d = OWN_VID;
            end else if (cpu_elig) begin
                owner_d = OWN_CPU;
            end else begin
                owner_d = OWN_IDLE;
            end

            prev_d    = owner_q;
            prev_we_d = mem_we_q;

            case (owner_d)
                OWN_VID: begin
                    mem_a_d  = vid_a;
                    mem_we_d = 1'b0;
                end
                OWN_CPU: begin
                    mem_a_d  = cpu_a;
                    mem_d_d  = cpu_d;
                    mem_we_d = cpu_we;
                end
                default: begin
                    mem_we_d = 1'b0;
                end
            endcase

            // prev_q names the slot whose memory access completed last edge.
            case (prev_q)
                OWN_VID: begin
                    vid_q_d     = mem_q;
                    vid_valid_d = 1'b1;
                end
                OWN_CPU: begin
                    cpu_ack_d = 1'b1;
                    if (!prev_we_q) begin
                        cpu_q_d = mem_q;
                    end
                end
                default: begin
                end
            endcase

`ifdef VRAM_ARBITER_STARVE_GUARD_EN
            vid_miss_d = force_cpu;
            if ((owner_d == OWN_VID) && cpu_elig) begin
                starve_d = starve_q + 3'd1;
            end else begin
                starve_d = 3'd0;
            end
`endif
        end
    end

    // State register; reset overrides ce and kills in-flight slots.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q     <= OWN_IDLE;
            prev_q      <= OWN_IDLE;
            prev_we_q   <= 1'b0;
            mem_a_q     <= 14'd0;
            mem_we_q    <= 1'b0;
            mem_d_q     <= 8'd0;
            vid_q_q     <= 8'd0;
            vid_valid_q <= 1'b0;
            cpu_q_q     <= 8'd0;
            cpu_ack_q   <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            prev_q      <= prev_d;
            prev_we_q   <= prev_we_d;
            mem_a_q     <= mem_a_d;
            mem_we_q    <= mem_we_d;
            mem_d_q     <= mem_d_d;
            vid_q_q     <= vid_q_d;
            vid_valid_q <= vid_valid_d;
            cpu_q_q     <= cpu_q_d;
            cpu_ack_q   <= cpu_ack_d;
        end
    end

`ifdef VRAM_ARBITER_STARVE_GUARD_EN
    // Starvation counter and dropped-fetch strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q   <= 3'd0;
            vid_miss_q <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            vid_miss_q <= vid_miss_d;
        end
    end

    assign vid_miss = vid_miss_q;
`else
    assign vid_miss = 1'b0;
`endif

    assign vid_q     = vid_q_q;
    assign vid_valid = vid_valid_q;
    assign cpu_q     = cpu_q_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_wait  = cpu_req & ~cpu_ack_q;
    assign mem_a     = mem_a_q;
    assign mem_we    = mem_we_q;
    assign mem_d     = mem_d_q;

endmodule
`default_nettype wire
